// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC/IR, fetches over a req/ack handshake,
// decodes IR fields, and applies branch/jump strobes from the control FSM.
module instr_fetch_unit #(
  parameter int             AW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          IRwrt,
  input  logic          PCwrt,
  input  logic          branch,
  input  logic          jump,
  input  logic          BNEoBEQ,
  input  logic          zero,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          stall,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [15:0]   ir,
  output logic [3:0]    op,
  output logic [3:0]    func,
  output logic [15:0]   imm8_se,
  output logic          seq_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   ir_q, ir_d;
  logic          inc_q, inc_d;
  logic          req_q, req_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  logic [AW-1:0] br_off;
  logic [AW-1:0] jmp_tgt;

  assign br_off  = {{(AW-8){ir_q[7]}}, ir_q[7:0]};
  assign jmp_tgt = {pc_q[AW-1:12], ir_q[11:0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    inc_d   = inc_q;
    req_d   = req_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // PC redirect lands first so a same-cycle fetch uses the new PC
        if (jump)                          pc_d = jmp_tgt;
        else if (branch && (zero ^ BNEoBEQ)) pc_d = pc_q + br_off;
        if (IRwrt) begin
          inc_d   = PCwrt;
          addr_d  = pc_d;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (branch || jump) err_d = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          if (inc_q) pc_d = pc_q + AW'(1);
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      inc_q   <= 1'b0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      inc_q   <= inc_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign stall       = req_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign op          = ir_q[15:12];
  assign func        = ir_q[3:0];
  assign imm8_se     = {{8{ir_q[7]}}, ir_q[7:0]};
  assign seq_err     = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/branch/jump vectors,
// memory responder checks addresses, monitor checks each IR load.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        IRwrt = 1'b0, PCwrt = 1'b0, branch = 1'b0, jump = 1'b0;
  logic        BNEoBEQ = 1'b0, zero = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr, imem_rdata = 16'h0;
  logic        stall, instr_valid, seq_err;
  logic [15:0] pc, ir, imm8_se;
  logic [3:0]  op, func;

  instr_fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .reset(reset), .IRwrt(IRwrt), .PCwrt(PCwrt), .branch(branch),
    .jump(jump), .BNEoBEQ(BNEoBEQ), .zero(zero), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .instr_valid(instr_valid), .pc(pc), .ir(ir), .op(op),
    .func(func), .imm8_se(imm8_se), .seq_err(seq_err)
  );

  always #5 CLK = ~CLK;

  int vecs = 0, errs = 0;
  int cyc = 0, issue_cyc = 0, valid_cyc = 0;
  int valid_cnt = 0, req_cyc = 0, stall_cyc = 0;
  int ack_wait = 0;
  bit auto_ack = 1'b1;
  logic [15:0] mem [65536];
  logic [15:0] exp_addr_q[$], exp_ir_q[$], exp_pc_q[$];

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // memory responder: acks after ack_wait idle req cycles, checks request address
  initial begin : responder
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge CLK);
      if (auto_ack) begin
        if (imem_req) begin
          rcnt++;
          if (rcnt > ack_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            if (exp_addr_q.size() == 0) chki("addr_unexpected_req", 1, 0);
            else chk16("imem_addr", imem_addr, exp_addr_q.pop_front());
          end else imem_ack = 1'b0;
        end else begin
          rcnt     = 0;
          imem_ack = 1'b0;
        end
      end
    end
  end

  // monitor: every IR load is compared against the scoreboard
  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge CLK);
      if (imem_req) req_cyc++;
      if (stall) stall_cyc++;
      if (instr_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        chki("valid_width", int'(prev_v), 0);
        if (exp_ir_q.size() == 0) chki("valid_unexpected", 1, 0);
        else begin
          chk16("ir", ir, exp_ir_q.pop_front());
          chk16("pc_after_fetch", pc, exp_pc_q.pop_front());
        end
      end
      prev_v = instr_valid;
    end
  end

  // mode 1: IRwrt pokes while busy; mode 2: branch/jump pokes while busy
  task automatic fetch(input logic inc, input logic [15:0] a, input logic [15:0] epc,
                       input int mode = 0, input logic br = 1'b0, input logic zr = 1'b0);
    int n0;
    exp_addr_q.push_back(a);
    exp_ir_q.push_back(mem[a]);
    exp_pc_q.push_back(epc);
    n0 = valid_cnt;
    @(negedge CLK);
    IRwrt = 1'b1; PCwrt = inc; branch = br; zero = zr; BNEoBEQ = 1'b0;
    @(posedge CLK);
    #1;
    issue_cyc = cyc;
    IRwrt = 1'b0; PCwrt = 1'b0; branch = 1'b0; zero = 1'b0;
    if (mode == 1) begin
      @(negedge CLK) IRwrt = 1'b1;
      @(negedge CLK) IRwrt = 1'b0;
      @(negedge CLK) IRwrt = 1'b1;
      @(negedge CLK) IRwrt = 1'b0;
    end else if (mode == 2) begin
      @(negedge CLK) begin branch = 1'b1; zero = 1'b1; end
      @(negedge CLK) begin branch = 1'b0; zero = 1'b0; jump = 1'b1; end
      @(negedge CLK) jump = 1'b0;
    end
    for (int i = 0; i < 30 && valid_cnt == n0; i++) @(negedge CLK);
    if (valid_cnt == n0) chki("fetch_timeout", 0, 1);
  endtask

  task automatic do_br(input logic br, input logic j, input logic z, input logic bne,
                       input logic [15:0] epc, input string nm);
    @(negedge CLK);
    branch = br; jump = j; zero = z; BNEoBEQ = bne;
    @(posedge CLK);
    #1;
    branch = 1'b0; jump = 1'b0; zero = 1'b0; BNEoBEQ = 1'b0;
    @(negedge CLK);
    chk16(nm, pc, epc);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, s0, v0;
    mem[16'h0000] = 16'h1234;  mem[16'h0001] = 16'h30FE;
    mem[16'h0002] = 16'h0001;  mem[16'h0003] = 16'h22FE;
    mem[16'h0004] = 16'h21FE;  mem[16'hFFFF] = 16'hB0FE;
    mem[16'hF0FE] = 16'h4123;  mem[16'hF146] = 16'h9ABC;
    mem[16'hF147] = 16'h1111;  mem[16'hF148] = 16'h2222;

    // reset state
    repeat (2) @(negedge CLK);
    chk16("rst_pc", pc, 16'h0000);
    chk16("rst_ir", ir, 16'h0000);
    chk16("rst_addr", imem_addr, 16'h0000);
    chk16("rst_dec", {op, func, imm8_se[7:0]}, 16'h0000);
    chk16("rst_ctl", {12'h0, imem_req, stall, instr_valid, seq_err}, 16'h0000);
    reset = 1'b1;

    // basic fetch, ack in first req cycle
    fetch(1'b1, 16'h0000, 16'h0001);
    chki("latency_min", valid_cyc - issue_cyc, 1);
    chk16("dec_op_func", {8'h0, op, func}, 16'h0014);
    chk16("dec_imm", imm8_se, 16'h0034);

    // wait states with ignored IRwrt pokes
    ack_wait = 3;
    r0 = req_cyc; s0 = stall_cyc; v0 = valid_cnt;
    fetch(1'b1, 16'h0001, 16'h0002, 1);
    chki("latency_wait", valid_cyc - issue_cyc, 4);
    chki("req_cycles", req_cyc - r0, 4);
    chki("stall_cycles", stall_cyc - s0, 4);
    repeat (6) @(negedge CLK);
    chki("no_queued_fetch", req_cyc - r0, 4);
    chki("one_ir_load", valid_cnt - v0, 1);
    ack_wait = 0;

    fetch(1'b1, 16'h0002, 16'h0003);
    fetch(1'b1, 16'h0003, 16'h0004);
    fetch(1'b1, 16'h0004, 16'h0005);
    do_br(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, "beq_not_taken");
    do_br(1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, "bne_not_taken");
    do_br(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, "bne_taken");
    fetch(1'b1, 16'h0003, 16'h0004);
    fetch(1'b1, 16'h0004, 16'h0005);
    do_br(1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, "beq_taken");
    do_br(1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, "beq_taken2");
    do_br(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, "branch_underflow");

    // increment wrap and jump precedence
    fetch(1'b1, 16'hFFFF, 16'h0000);
    do_br(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, "branch_from_zero");
    do_br(1'b1, 1'b1, 1'b1, 1'b0, 16'hF0FE, "jump_beats_branch");
    fetch(1'b1, 16'hF0FE, 16'hF0FF);
    chk16("dec_4123", {op, func, imm8_se[7:0]}, 16'h4323);
    do_br(1'b0, 1'b1, 1'b0, 1'b0, 16'hF123, "jump");

    // branch with IRwrt in same cycle: fetch from the branch target
    fetch(1'b1, 16'hF146, 16'hF147, 0, 1'b1, 1'b1);
    chk16("dec_neg_imm", imm8_se, 16'hFFBC);
    chk16("seq_err_clear", {15'h0, seq_err}, 16'h0000);

    // branch/jump while busy: PC only increments, seq_err sticks
    ack_wait = 3;
    fetch(1'b1, 16'hF147, 16'hF148, 2);
    chk16("seq_err_set", {15'h0, seq_err}, 16'h0001);
    ack_wait = 0;
    fetch(1'b0, 16'hF148, 16'hF148);
    chk16("seq_err_sticky", {15'h0, seq_err}, 16'h0001);

    // reset mid-fetch, late ack afterwards must be ignored
    auto_ack = 1'b0;
    @(negedge CLK);
    IRwrt = 1'b1; PCwrt = 1'b1;
    @(posedge CLK);
    #1;
    IRwrt = 1'b0; PCwrt = 1'b0;
    @(negedge CLK);
    chk16("req_before_rst", {15'h0, imem_req}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    chk16("midrst_ctl", {12'h0, imem_req, stall, instr_valid, seq_err}, 16'h0000);
    chk16("midrst_pc", pc, 16'h0000);
    chk16("midrst_ir", ir, 16'h0000);
    chk16("midrst_addr", imem_addr, 16'h0000);
    chk16("midrst_dec", {op, func, imm8_se[7:0]}, 16'h0000);
    v0 = valid_cnt;
    @(negedge CLK) reset = 1'b1;
    @(negedge CLK) begin imem_ack = 1'b1; imem_rdata = 16'hFFFF; end
    @(negedge CLK) imem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk16("late_ack_ir", ir, 16'h0000);
    chk16("late_ack_pc", pc, 16'h0000);
    chki("late_ack_no_valid", valid_cnt - v0, 0);
    chk16("late_ack_req", {15'h0, imem_req}, 16'h0000);

    chki("scoreboard_drained", exp_ir_q.size() + exp_addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the multicycle main control FSM. It owns the program counter (PC) and instruction register (IR), issues requests to instruction memory over a req/ack handshake, and decodes the IR fields (op, func, immediates) that the control FSM and datapath consume. It also applies the control FSM's branch and jump strobes to the PC.

## Interface
- AW, 16, PC and instruction memory address width (word addressed)
- RESET_PC, 16'h0000, PC value after reset
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active low
- IRwrt  in  1  fetch strobe from control (FETCH state); starts a fetch when the unit is idle
- PCwrt  in  1  sampled with IRwrt; if 1, the PC increments when the fetch completes
- branch  in  1  branch strobe from control
- jump  in  1  jump strobe from control
- BNEoBEQ  in  1  branch sense: 0 = BEQ (taken if zero), 1 = BNE (taken if !zero)
- zero  in  1  ALU equality flag (A == B), valid while branch is high
- imem_req  out  1  instruction memory request
- imem_addr  out  AW  request address, equal to the PC latched at fetch start
- imem_rdata  in  16  instruction word, valid when imem_ack is high
- imem_ack  in  1  memory acknowledge; the word transfers when imem_req and imem_ack are both high
- stall  out  1  high while a fetch is outstanding; control holds its state
- instr_valid  out  1  one-cycle pulse after the IR is loaded
- pc  out  AW  current PC
- ir  out  16  instruction register
- op  out  4  ir[15:12]
- func  out  4  ir[3:0]
- imm8_se  out  16  sign-extended ir[7:0]
- seq_err  out  1  sticky flag; set when branch or jump arrives while a fetch is busy

## Operation
- The FSM has two states: IDLE and BUSY.
- **IDLE, IRwrt=1:**
  - Latch the PCwrt value into inc_pend.
  - Drive imem_addr with the current pc.
  - Move to BUSY. imem_req and stall are high from the next cycle.
- **BUSY:**
  - Hold imem_req and imem_addr until the clock edge where imem_ack=1.
  - At that edge: ir is loaded from imem_rdata; pc becomes pc+1 if inc_pend=1; the FSM returns to IDLE.
  - The edge after the transfer edge: imem_req=0, stall=0, instr_valid=1 for one cycle.
- **IRwrt while BUSY:** ignored. It is not queued.
- **Branch in IDLE:**
  - Taken if (zero ^ BNEoBEQ)=1. Then pc becomes pc + imm8_se, modulo 2^AW wrap.
  - pc has already been incremented, so the target is relative to the next instruction.
  - Not taken: pc is unchanged.
- **Jump in IDLE:** pc becomes {pc[AW-1:12], ir[11:0]}.
- **Jump and branch in the same cycle:** jump wins.
- **IRwrt together with branch or jump:** the PC update is applied first. The fetch then uses the updated pc, so imem_addr is the new pc.
- **Branch or jump while BUSY:** the PC is not modified and seq_err is set. seq_err clears only on reset.
- **PC overflow:** pc+1 at all-ones wraps to 0.
- **Reset (async, reset=0), including mid-fetch:**
  - pc = RESET_PC; ir = 0; FSM = IDLE.
  - imem_req, stall, instr_valid and seq_err = 0; inc_pend = 0; imem_addr = RESET_PC.
  - An outstanding request is dropped. A late imem_ack after reset release is ignored.
- op, func and imm8_se are combinational decodes of ir. At reset they are 0.

## Timing
- Minimum fetch latency is 2 edges when ack comes in the first cycle of req:
  - IRwrt sampled at edge N.
  - imem_req high N→N+1, with ack in that cycle.
  - ir and pc update at N+1.
  - instr_valid high N+1→N+2.
- Each cycle of ack delay adds one cycle to the latency.
- A branch or jump updates pc at the same edge it is sampled. The new pc is visible the next cycle.
- imem_addr and imem_req are registered outputs; they do not glitch.

## Test plan
- **Reset and basic fetch:** reset low, then release; RESET_PC=0; mem[0]=16'h1234; IRwrt=PCwrt=1 for one cycle; ack on the first req cycle → imem_addr=0; ir=16'h1234; op=1; func=4; pc=1; instr_valid pulses 2 edges after IRwrt.
- **Wait states:** ack delayed 3 cycles → imem_req and stall held high for 4 cycles; IRwrt pulses during BUSY are ignored; exactly one IR load.
- **Branches:**
  - pc=5, ir[7:0]=8'hFE, branch=1, BNEoBEQ=0, zero=1 → pc=3.
  - The same with zero=0 → pc=5.
  - BNEoBEQ=1, zero=0 → pc=3.
- **Jump and simultaneous events:** pc=16'hA005, ir=16'h4123, jump=branch=1 → pc=16'hA123. Branch or jump while BUSY → pc unchanged, seq_err=1.
- **Wrap-around:** pc=16'hFFFF, fetch with PCwrt=1 → pc=0. pc=1 with imm8_se=-2 and branch taken → pc=16'hFFFF.
- **Reset mid-fetch:** assert reset while imem_req=1 → imem_req falls immediately and all outputs take their reset values. An ack one cycle after release → ir stays 0 and no instr_valid.
